// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: controller states, zero-register id, hazard reason codes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_t;

   localparam int unsigned REG_ZERO = 0;

   // Reason codes are also consumed by the forwarding unit, so keep the encoding stable.
   typedef enum logic [2:0] {
      HZ_NONE        = 3'd0,
      HZ_LOAD_USE    = 3'd1,
      HZ_BR_EX       = 3'd2,
      HZ_BR_MEM_LOAD = 3'd3,
      HZ_MD_BUSY     = 3'd4,
      HZ_MEM_WAIT    = 3'd5
   } hz_reason_t;

   function automatic logic is_id_bubble(input hz_reason_t r);
      return (r == HZ_LOAD_USE) || (r == HZ_BR_EX) || (r == HZ_BR_MEM_LOAD);
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// MUL/DIV occupancy timer: load MD_LAT-1, count down, hold while frozen.
// Latency: busy the cycle after load; last is combinational on the final count.
// Backpressure: freeze holds the count and masks last.
module md_busy_timer #(
   parameter int MD_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic freeze,
   output logic busy,
   output logic last
);

   logic [3:0] md_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt <= 4'd0;
      end else if (!freeze) begin
         if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
         end else if (load) begin
            md_cnt <= 4'(MD_LAT - 1);
         end
      end
   end

   assign busy = (md_cnt != 4'd0);
   assign last = (md_cnt == 4'd1) && !freeze;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for hazards forwarding cannot cover (load-use, branch, MUL/DIV, dmem wait).
// Latency: all enables combinational from state and match terms; no added release latency.
// Backpressure: memory wait freezes every stage; MUL/DIV drains older stages behind a bubble.
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] if_id_rs,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic [REG_W-1:0] id_ex_dst,
   input  logic             id_ex_regwrite,
   input  logic             id_ex_memread,
   input  logic [REG_W-1:0] ex_mem_dst,
   input  logic             ex_mem_regwrite,
   input  logic             ex_mem_memread,
   input  logic             ex_md_start,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             ex_mem_bubble,
   output logic             mem_wb_en,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [REG_W-1:0] DST_ZERO = REG_W'(REG_ZERO);

   ctrl_state_t state, state_nxt, eff_state;
   hz_reason_t  reason;

   logic mem_stall, ex_match, mem_match, md_busy, md_last, md_load;
   logic c_pc_en, c_if_id_en, c_id_ex_en, c_id_ex_bubble;
   logic c_ex_mem_en, c_ex_mem_bubble, c_mem_wb_en, c_md_done;

   assign mem_stall = dmem_req && !dmem_ready;

   // regwrite is active-low; r0 is never a real producer.
   assign ex_match  = !id_ex_regwrite && (id_ex_dst != DST_ZERO) &&
                      ((id_ex_dst == if_id_rs) || (id_uses_rt && (id_ex_dst == if_id_rt)));
   assign mem_match = !ex_mem_regwrite && (ex_mem_dst != DST_ZERO) &&
                      ((ex_mem_dst == if_id_rs) || (id_uses_rt && (ex_mem_dst == if_id_rt)));

   // Leaving MEM_WAIT behaves as the interrupted state in the same cycle.
   assign eff_state = (state == MEM_WAIT) ? (md_busy ? MD_BUSY : RUN) : state;

   always_comb begin
      reason = HZ_NONE;
      if (mem_stall) begin
         reason = HZ_MEM_WAIT;
      end else if (eff_state == MD_BUSY) begin
         reason = HZ_MD_BUSY;
      end else if (id_ex_memread && ex_match) begin
         reason = HZ_LOAD_USE;
      end else if (id_is_branch && ex_match) begin
         reason = HZ_BR_EX;
      end else if (id_is_branch && ex_mem_memread && mem_match) begin
         reason = HZ_BR_MEM_LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = RUN;
      md_load         = 1'b0;
      c_pc_en         = 1'b1;
      c_if_id_en      = 1'b1;
      c_id_ex_en      = 1'b1;
      c_id_ex_bubble  = 1'b0;
      c_ex_mem_en     = 1'b1;
      c_ex_mem_bubble = 1'b0;
      c_mem_wb_en     = 1'b1;
      c_md_done       = 1'b0;
      case (reason)
         HZ_MEM_WAIT: begin
            state_nxt   = MEM_WAIT;
            c_pc_en     = 1'b0;
            c_if_id_en  = 1'b0;
            c_id_ex_en  = 1'b0;
            c_ex_mem_en = 1'b0;
            c_mem_wb_en = 1'b0;
         end
         HZ_MD_BUSY: begin
            state_nxt       = md_last ? RUN : MD_BUSY;
            c_pc_en         = 1'b0;
            c_if_id_en      = 1'b0;
            c_id_ex_en      = 1'b0;
            c_ex_mem_bubble = 1'b1;
            c_md_done       = md_last;
         end
         default: begin
            if (is_id_bubble(reason)) begin
               c_pc_en        = 1'b0;
               c_if_id_en     = 1'b0;
               c_id_ex_bubble = 1'b1;
            end
            if (ex_md_start) begin
               md_load   = 1'b1;
               state_nxt = MD_BUSY;
            end
         end
      endcase
   end

   md_busy_timer #(
      .MD_LAT (MD_LAT)
   ) u_md_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (md_load),
      .freeze (mem_stall),
      .busy   (md_busy),
      .last   (md_last)
   );

   // Reset overrides outputs only, so no flop sees rst_n as data.
   assign pc_en         = rst_n && c_pc_en;
   assign if_id_en      = rst_n && c_if_id_en;
   assign id_ex_en      = rst_n && c_id_ex_en;
   assign id_ex_bubble  = !rst_n || c_id_ex_bubble;
   assign ex_mem_en     = rst_n && c_ex_mem_en;
   assign ex_mem_bubble = !rst_n || c_ex_mem_bubble;
   assign mem_wb_en     = rst_n && c_mem_wb_en;
   assign md_done       = rst_n && c_md_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (!c_pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a cycle-level reference model and literal anchors.
module tb_hazard_stall_ctrl;

   localparam int REG_W   = 5;
   localparam int MD_LAT  = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
   logic             id_uses_rt, id_is_branch, id_ex_regwrite, id_ex_memread;
   logic             ex_mem_regwrite, ex_mem_memread, ex_md_start, dmem_req, dmem_ready;
   logic             pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_bubble;
   logic             mem_wb_en, md_done;
   logic [CNT_W-1:0] stall_cycles;

   int errors = 0;
   int checks = 0;
   int m_md_left = 0;
   int m_stalls = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_W  (REG_W),
      .MD_LAT (MD_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_is_branch    (id_is_branch),
      .id_ex_dst       (id_ex_dst),
      .id_ex_regwrite  (id_ex_regwrite),
      .id_ex_memread   (id_ex_memread),
      .ex_mem_dst      (ex_mem_dst),
      .ex_mem_regwrite (ex_mem_regwrite),
      .ex_mem_memread  (ex_mem_memread),
      .ex_md_start     (ex_md_start),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .id_ex_bubble    (id_ex_bubble),
      .ex_mem_en       (ex_mem_en),
      .ex_mem_bubble   (ex_mem_bubble),
      .mem_wb_en       (mem_wb_en),
      .md_done         (md_done),
      .stall_cycles    (stall_cycles)
   );

   // ---------------- reference model ----------------
   function automatic bit reads(input logic [REG_W-1:0] dst, input logic regwrite_n);
      if (regwrite_n || dst == 0) return 1'b0;
      return (dst == if_id_rs) || (id_uses_rt && dst == if_id_rt);
   endfunction

   function automatic bit id_hazard();
      return (id_ex_memread && reads(id_ex_dst, id_ex_regwrite)) ||
             (id_is_branch && reads(id_ex_dst, id_ex_regwrite)) ||
             (id_is_branch && ex_mem_memread && reads(ex_mem_dst, ex_mem_regwrite));
   endfunction

   // Bit order: pc, if_id, id_ex, id_ex_bubble, ex_mem, ex_mem_bubble, mem_wb, md_done
   function automatic logic [7:0] model_out();
      if (!rst_n) return 8'b0001_0100;
      if (dmem_req && !dmem_ready) return 8'b0000_0000;
      if (m_md_left > 0) return (m_md_left == 1) ? 8'b0000_1111 : 8'b0000_1110;
      if (id_hazard()) return 8'b0011_1010;
      return 8'b1110_1010;
   endfunction

   always @(posedge clk) begin
      logic [7:0] e;
      if (rst_n) begin
         e = model_out();
         if (e[7] == 1'b0) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
         if (!(dmem_req && !dmem_ready)) begin
            if (m_md_left > 0) m_md_left = m_md_left - 1;
            else if (ex_md_start) m_md_left = MD_LAT - 1;
         end
      end
   end

   always @(negedge rst_n) begin
      m_md_left = 0;
      m_stalls  = 0;
   end

   always @(negedge clk) begin
      logic [7:0] dut_v;
      logic [7:0] exp_v;
      dut_v = {pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_bubble, mem_wb_en, md_done};
      exp_v = model_out();
      checks++;
      if (dut_v !== exp_v) begin
         errors++;
         $display("FAIL ctrl_vec t=%0t: got %b expected %b", $time, dut_v, exp_v);
      end
      checks++;
      if (stall_cycles !== CNT_W'(m_stalls)) begin
         errors++;
         $display("FAIL stall_cycles t=%0t: got %0d expected %0d", $time, stall_cycles, m_stalls);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      if_id_rs        = '0;
      if_id_rt        = '0;
      id_uses_rt      = 1'b0;
      id_is_branch    = 1'b0;
      id_ex_dst       = '0;
      id_ex_regwrite  = 1'b1;
      id_ex_memread   = 1'b0;
      ex_mem_dst      = '0;
      ex_mem_regwrite = 1'b1;
      ex_mem_memread  = 1'b0;
      ex_md_start     = 1'b0;
      dmem_req        = 1'b0;
      dmem_ready      = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pc_low, done_at, done_cnt, bub, wait_memwb, wait_bub;

      idle();
      repeat (3) cyc();
      chk("reset_pc_en", int'(pc_en), 0);
      chk("reset_id_ex_bubble", int'(id_ex_bubble), 1);
      chk("reset_ex_mem_bubble", int'(ex_mem_bubble), 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("run_pc_en", int'(pc_en), 1);
      chk("run_count", int'(stall_cycles), 0);

      // load-use
      cyc();
      id_ex_memread = 1'b1; id_ex_regwrite = 1'b0; id_ex_dst = 5'd8; if_id_rs = 5'd8;
      @(negedge clk);
      chk("load_use_pc_en", int'(pc_en), 0);
      chk("load_use_bubble", int'(id_ex_bubble), 1);
      cyc();
      idle();
      @(negedge clk);
      chk("load_use_count", int'(stall_cycles), 1);
      chk("load_use_release", int'(pc_en), 1);

      // non-matching load-use variants
      cyc();
      id_ex_memread = 1'b1; id_ex_regwrite = 1'b0; id_ex_dst = 5'd0; if_id_rs = 5'd0;
      @(negedge clk);
      chk("dst_zero_no_stall", int'(pc_en), 1);
      cyc();
      id_ex_dst = 5'd8; if_id_rs = 5'd8; id_ex_regwrite = 1'b1;
      @(negedge clk);
      chk("no_write_no_stall", int'(pc_en), 1);
      cyc();
      id_ex_regwrite = 1'b0; if_id_rs = 5'd3; if_id_rt = 5'd8; id_uses_rt = 1'b0;
      @(negedge clk);
      chk("rt_unused_no_stall", int'(pc_en), 1);
      cyc();
      id_uses_rt = 1'b1;
      @(negedge clk);
      chk("rt_used_stall", int'(pc_en), 0);
      cyc();
      idle();

      // MUL/DIV occupancy
      cyc();
      ex_md_start = 1'b1;
      @(negedge clk);
      chk("md_start_cycle_pc_en", int'(pc_en), 1);
      cyc();
      ex_md_start = 1'b0;
      pc_low = 0; done_at = -1; done_cnt = 0; bub = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!pc_en) pc_low++;
         if (md_done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (ex_mem_bubble) bub++;
         cyc();
      end
      chk("md_stall_len", pc_low, 3);
      chk("md_done_cycle", done_at, 2);
      chk("md_done_pulses", done_cnt, 1);
      chk("md_ex_mem_bubbles", bub, 3);

      // memory wait arriving mid-MD
      ex_md_start = 1'b1;
      cyc();
      ex_md_start = 1'b0;
      pc_low = 0; done_at = -1; wait_memwb = 1; wait_bub = 1;
      for (int i = 0; i < 8; i++) begin
         dmem_req   = (i >= 1 && i <= 3);
         dmem_ready = (i == 3);
         @(negedge clk);
         if (!pc_en) pc_low++;
         if (md_done && done_at < 0) done_at = i;
         if (i == 1) begin
            wait_memwb = int'(mem_wb_en);
            wait_bub   = int'(ex_mem_bubble);
         end
         cyc();
      end
      idle();
      chk("md_mem_stall_len", pc_low, 5);
      chk("md_mem_done_cycle", done_at, 4);
      chk("mem_wait_mem_wb_en", wait_memwb, 0);
      chk("mem_wait_no_bubble", wait_bub, 0);

      // branch vs load in MEM, and vs EX
      id_is_branch = 1'b1; if_id_rs = 5'd5;
      ex_mem_memread = 1'b1; ex_mem_regwrite = 1'b0; ex_mem_dst = 5'd5;
      @(negedge clk);
      chk("br_mem_load_pc_en", int'(pc_en), 0);
      chk("br_mem_load_bubble", int'(id_ex_bubble), 1);
      cyc();
      ex_mem_memread = 1'b0;
      @(negedge clk);
      chk("br_mem_alu_pc_en", int'(pc_en), 1);
      chk("br_mem_alu_bubble", int'(id_ex_bubble), 0);
      cyc();
      id_ex_dst = 5'd5; id_ex_regwrite = 1'b0;
      @(negedge clk);
      chk("br_ex_pc_en", int'(pc_en), 0);
      cyc();
      idle();

      // async reset in the last MD cycle
      cyc();
      ex_md_start = 1'b1;
      cyc();
      ex_md_start = 1'b0;
      cyc();
      cyc();
      #2;
      chk("pre_reset_md_done", int'(md_done), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc_en", int'(pc_en), 0);
      chk("async_rst_mem_wb_en", int'(mem_wb_en), 0);
      chk("async_rst_ex_mem_en", int'(ex_mem_en), 0);
      chk("async_rst_id_ex_bubble", int'(id_ex_bubble), 1);
      chk("async_rst_ex_mem_bubble", int'(ex_mem_bubble), 1);
      chk("async_rst_md_done", int'(md_done), 0);
      chk("async_rst_count", int'(stall_cycles), 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_pc_en", int'(pc_en), 1);
      chk("post_rst_count", int'(stall_cycles), 0);
      cyc();
      @(negedge clk);
      chk("post_rst_still_run", int'(pc_en), 1);

      // counter saturation
      cyc();
      id_ex_memread = 1'b1; id_ex_regwrite = 1'b0; id_ex_dst = 5'd8; if_id_rs = 5'd8;
      repeat (20) cyc();
      @(negedge clk);
      chk("saturate_count", int'(stall_cycles), CNT_MAX);
      cyc();
      idle();
      @(negedge clk);
      chk("saturate_hold", int'(stall_cycles), CNT_MAX);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
